// File: rtl/rc4_multicore_search_master.sv
// RC4 key-search master: runs NUM_CORES init/swap/decode core chains in
// parallel. Each core walks its own interleaved key slice, the first cracked
// key (lowest core index on a tie) is latched, and fail is raised once every
// core has run off the end of its slice.
module rc4_multicore_search_master #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] LOW_KEY  = 24'h000000,
  parameter logic [KEY_WIDTH-1:0] HIGH_KEY = 24'h000100,
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           go,
  output logic [NUM_CORES-1:0]           init_start,
  input  logic [NUM_CORES-1:0]           init_finish,
  output logic [NUM_CORES-1:0]           swap_start,
  input  logic [NUM_CORES-1:0]           swap_finish,
  output logic [NUM_CORES-1:0]           decode_start,
  input  logic [NUM_CORES-1:0]           decode_finish,
  input  logic [NUM_CORES-1:0]           abort,
  output logic [2*NUM_CORES-1:0]         addr_data_sel,
  output logic [KEY_WIDTH*NUM_CORES-1:0] secret_key,
  output logic [NUM_CORES-1:0]           core_reset,
  output logic                           busy,
  output logic                           pass,
  output logic                           fail,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [IDX_W-1:0]               found_core,
  output logic [KEY_WIDTH-1:0]           keys_tested
);

  typedef enum logic [1:0] {G_IDLE, G_RUN, G_PASS, G_FAIL} g_state_t;

  typedef enum logic [3:0] {
    C_IDLE, C_CHECK, C_INIT_GO, C_INIT_WAIT, C_SWAP_GO, C_SWAP_WAIT,
    C_DEC_GO, C_DEC_WAIT, C_NEXT, C_EXHAUSTED, C_HALT
  } c_state_t;

  g_state_t             g_q, g_d;
  c_state_t             core_q [NUM_CORES];
  c_state_t             core_d [NUM_CORES];
  logic [KEY_WIDTH-1:0] key_q  [NUM_CORES];
  logic [KEY_WIDTH-1:0] key_d  [NUM_CORES];
  // Set when a core's key arithmetic carried out of KEY_WIDTH bits.
  logic [NUM_CORES-1:0] wrap_q, wrap_d;

  logic                 busy_q, busy_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  // High for the first cycle of G_PASS: drives the losers' clear pulse.
  logic                 halt_pulse_q, halt_pulse_d;
  logic [KEY_WIDTH-1:0] found_key_q, found_key_d;
  logic [IDX_W-1:0]     found_core_q, found_core_d;
  logic [KEY_WIDTH-1:0] keys_tested_q, keys_tested_d;

  logic                 hit_any;
  logic [IDX_W-1:0]     hit_idx;
  logic [KEY_WIDTH-1:0] hit_key;
  logic                 all_exhausted;
  logic [KEY_WIDTH-1:0] reject_cnt;
  logic [KEY_WIDTH:0]   key_sum;
  logic [KEY_WIDTH:0]   init_sum;

  // Memory mux select for one core; the winner keeps the plaintext RAM.
  function automatic logic [1:0] sel_for(input c_state_t s, input logic winner);
    case (s)
      C_SWAP_GO, C_SWAP_WAIT: return 2'b01;
      C_DEC_GO, C_DEC_WAIT:   return 2'b11;
      C_HALT:                 return winner ? 2'b11 : 2'b00;
      default:                return 2'b00;
    endcase
  endfunction

  // Find the lowest-index cracked key, count rejects, detect exhaustion.
  always_comb begin : detect_comb
    hit_any       = 1'b0;
    hit_idx       = '0;
    hit_key       = '0;
    all_exhausted = 1'b1;
    reject_cnt    = '0;
    // Descending scan so the lowest index is the last one written.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_q[i] == C_DEC_WAIT && decode_finish[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
        hit_key = key_q[i];
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_q[i] != C_EXHAUSTED) begin
        all_exhausted = 1'b0;
      end
      if (core_q[i] == C_DEC_WAIT && abort[i] && !decode_finish[i]) begin
        reject_cnt = reject_cnt + KEY_WIDTH'(1);
      end
    end
  end

  // Global search FSM: idle, running, and the two sticky verdicts.
  always_comb begin : global_next_comb
    g_d           = g_q;
    found_key_d   = found_key_q;
    found_core_d  = found_core_q;
    keys_tested_d = keys_tested_q;
    halt_pulse_d  = 1'b0;
    case (g_q)
      G_IDLE: begin
        if (go) begin
          g_d           = G_RUN;
          keys_tested_d = '0;
        end
      end
      G_RUN: begin
        if (hit_any) begin
          g_d          = G_PASS;
          found_key_d  = hit_key;
          found_core_d = hit_idx;
          halt_pulse_d = 1'b1;
        end else begin
          keys_tested_d = keys_tested_q + reject_cnt;
          if (all_exhausted) begin
            g_d = G_FAIL;
          end
        end
      end
      default: ;
    endcase
    busy_d = (g_d == G_RUN);
    pass_d = (g_d == G_PASS);
    fail_d = (g_d == G_FAIL);
  end

  // Per-core phase sequencing and key stepping.
  always_comb begin : core_next_comb
    key_sum  = '0;
    init_sum = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_d[i] = core_q[i];
      key_d[i]  = key_q[i];
      wrap_d[i] = wrap_q[i];
      key_sum   = {1'b0, key_q[i]} + (KEY_WIDTH+1)'(NUM_CORES);
      init_sum  = {1'b0, LOW_KEY} + (KEY_WIDTH+1)'(i);
      if (g_q == G_IDLE) begin
        if (go) begin
          core_d[i] = C_CHECK;
          key_d[i]  = init_sum[KEY_WIDTH-1:0];
          wrap_d[i] = init_sum[KEY_WIDTH];
        end
      end else if (g_q == G_RUN && hit_any) begin
        // A key was cracked: every core stops, pending starts never issue.
        core_d[i] = C_HALT;
      end else if (g_q == G_RUN) begin
        case (core_q[i])
          C_CHECK:     core_d[i] = (wrap_q[i] || key_q[i] >= HIGH_KEY) ? C_EXHAUSTED : C_INIT_GO;
          C_INIT_GO:   core_d[i] = C_INIT_WAIT;
          C_INIT_WAIT: if (init_finish[i]) core_d[i] = C_SWAP_GO;
          C_SWAP_GO:   core_d[i] = C_SWAP_WAIT;
          C_SWAP_WAIT: if (swap_finish[i]) core_d[i] = C_DEC_GO;
          C_DEC_GO:    core_d[i] = C_DEC_WAIT;
          C_DEC_WAIT: begin
            if (decode_finish[i]) begin
              core_d[i] = C_HALT;
            end else if (abort[i]) begin
              core_d[i] = C_NEXT;
            end
          end
          C_NEXT: begin
            key_d[i]  = key_sum[KEY_WIDTH-1:0];
            wrap_d[i] = wrap_q[i] | key_sum[KEY_WIDTH];
            core_d[i] = C_CHECK;
          end
          default: ;
        endcase
      end
    end
  end

  // Global state and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      g_q           <= G_IDLE;
      busy_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      halt_pulse_q  <= 1'b0;
      found_key_q   <= '0;
      found_core_q  <= '0;
      keys_tested_q <= '0;
    end else begin
      g_q           <= g_d;
      busy_q        <= busy_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      halt_pulse_q  <= halt_pulse_d;
      found_key_q   <= found_key_d;
      found_core_q  <= found_core_d;
      keys_tested_q <= keys_tested_d;
    end
  end

  // Per-core state, key and wrap registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrap_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        core_q[i] <= C_IDLE;
        key_q[i]  <= LOW_KEY + KEY_WIDTH'(i);
      end
    end else begin
      wrap_q <= wrap_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        core_q[i] <= core_d[i];
        key_q[i]  <= key_d[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core_out
      logic is_winner;
      assign is_winner   = pass_q && (found_core_q == IDX_W'(gi));
      assign init_start[gi]   = (core_q[gi] == C_INIT_GO);
      assign swap_start[gi]   = (core_q[gi] == C_SWAP_GO);
      assign decode_start[gi] = (core_q[gi] == C_DEC_GO);
      assign core_reset[gi]   = (core_q[gi] == C_NEXT) || (halt_pulse_q && !is_winner);
      assign addr_data_sel[2*gi +: 2]          = sel_for(core_q[gi], is_winner);
      assign secret_key[gi*KEY_WIDTH +: KEY_WIDTH] = key_q[gi];
    end
  endgenerate

  assign busy        = busy_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign found_key   = found_key_q;
  assign found_core  = found_core_q;
  assign keys_tested = keys_tested_q;

endmodule

// File: tb/tb_rc4_multicore_search_master.sv
// Scoreboard bench for rc4_multicore_search_master: 4 cores, keys 0x00..0x0F.
// Per-core responders play the init/swap/decode datapaths in lockstep; the
// monitor pops expected decode keys and final verdicts from queues.
module tb_rc4_multicore_search_master;

  localparam logic [95:0] INIT_KEYS = {24'd3, 24'd2, 24'd1, 24'd0};

  typedef struct packed {
    logic        p;
    logic        f;
    logic [23:0] fk;
    logic [1:0]  fc;
    logic [23:0] kt;
  } res_t;

  logic        clk, reset, go;
  logic [3:0]  init_start, init_finish, swap_start, swap_finish;
  logic [3:0]  decode_start, decode_finish, abort, core_reset;
  logic [7:0]  addr_data_sel;
  logic [95:0] secret_key;
  logic        busy, pass, fail;
  logic [23:0] found_key, keys_tested;
  logic [1:0]  found_core;

  int tests_run = 0;
  int tests_failed = 0;
  int test_id = 0;
  int cyc = 0;
  int done_seen = 0;
  int post_starts = 0;
  int run_creset = 0;
  int post_creset [4];
  int last_swap [4];
  logic [31:0] dec_exp_q [$];
  res_t        res_exp_q [$];

  rc4_multicore_search_master #(
    .NUM_CORES(4), .KEY_WIDTH(24), .LOW_KEY(24'h000000), .HIGH_KEY(24'h000010)
  ) dut (
    .clock(clk), .reset(reset), .go(go),
    .init_start(init_start), .init_finish(init_finish),
    .swap_start(swap_start), .swap_finish(swap_finish),
    .decode_start(decode_start), .decode_finish(decode_finish), .abort(abort),
    .addr_data_sel(addr_data_sel), .secret_key(secret_key), .core_reset(core_reset),
    .busy(busy), .pass(pass), .fail(fail),
    .found_key(found_key), .found_core(found_core), .keys_tested(keys_tested)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  function automatic logic [23:0] key_of(input int c);
    return secret_key[c*24 +: 24];
  endfunction

  // Decode verdict per test: 0 reject, 1 cracked, 2 cracked and reject together.
  function automatic int resp(input int c, input logic [23:0] k);
    if (test_id == 2 && c == 2 && k == 24'h06) return 1;
    if (test_id == 3 && ((c == 1 && k == 24'h05) || (c == 3 && k == 24'h07))) return 1;
    if (test_id == 4 && c == 0 && k == 24'h00) return 2;
    return 0;
  endfunction

  // Datapath stand-in for core c; test 5 also injects out-of-phase strobes.
  task automatic responder(input int c);
    int ci, cs, cd, r;
    ci = -1; cs = -1; cd = -1;
    forever begin
      @(negedge clk);
      init_finish[c] = 1'b0; swap_finish[c] = 1'b0;
      decode_finish[c] = 1'b0; abort[c] = 1'b0;
      if (reset) begin
        ci = -1; cs = -1; cd = -1;
      end else begin
        if (init_start[c]) ci = 0; else if (ci >= 0) ci++;
        if (swap_start[c]) cs = 0; else if (cs >= 0) cs++;
        if (decode_start[c]) cd = 0; else if (cd >= 0) cd++;
        if (test_id == 5 && ci == 1) abort[c] = 1'b1;
        if (test_id == 5 && cs == 1) init_finish[c] = 1'b1;
        if (ci == 3) begin init_finish[c] = 1'b1; ci = -1; end
        if (cs == 3) begin swap_finish[c] = 1'b1; cs = -1; end
        if (cd == 2) begin
          r = resp(c, key_of(c));
          if (r >= 1) decode_finish[c] = 1'b1;
          if (r != 1) abort[c] = 1'b1;
          cd = -1;
        end
      end
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a decode start or verdict.
  always @(negedge clk) begin
    res_t e;
    logic [31:0] k;
    cyc++;
    if (reset) begin
      done_seen = 0; post_starts = 0; run_creset = 0;
      for (int c = 0; c < 4; c++) post_creset[c] = 0;
    end else begin
      if (done_seen == 0 && (pass || fail)) begin
        done_seen = 1;
        if (res_exp_q.size() == 0) begin
          check("unexpected_verdict", {pass, fail}, 2'b00);
        end else begin
          e = res_exp_q.pop_front();
          check("verdict_pass", pass, e.p);
          check("verdict_fail", fail, e.f);
          check("verdict_busy", busy, 1'b0);
          check("verdict_keys_tested", keys_tested, e.kt);
          if (e.p) begin
            check("verdict_found_key", found_key, e.fk);
            check("verdict_found_core", found_core, e.fc);
          end
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (swap_start[c]) begin
          last_swap[c] = cyc;
          check($sformatf("sel_swap_c%0d", c), addr_data_sel[2*c +: 2], 2'b01);
        end
        if (decode_start[c]) begin
          check($sformatf("sel_dec_c%0d", c), addr_data_sel[2*c +: 2], 2'b11);
          check($sformatf("swap_to_dec_gap_c%0d", c), cyc - last_swap[c], 4);
          if (dec_exp_q.size() == 0) begin
            check($sformatf("unexpected_decode_c%0d", c), 1'b1, 1'b0);
          end else begin
            k = dec_exp_q.pop_front();
            check("decode_core_key", {8'(c), key_of(c)}, k);
          end
        end
      end
      if (done_seen != 0) begin
        if (|{init_start, swap_start, decode_start}) post_starts++;
        for (int c = 0; c < 4; c++) post_creset[c] += int'(core_reset[c]);
      end else begin
        run_creset += $countones(core_reset);
      end
    end
  end

  task automatic push_round(input int r);
    for (int c = 0; c < 4; c++) dec_exp_q.push_back({8'(c), 24'(r*4 + c)});
  endtask

  task automatic do_reset();
    reset = 1'b1; go = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_pass_fail", {pass, fail}, 2'b00);
    check("reset_keys_tested", keys_tested, 24'd0);
    check("reset_found", {found_key, found_core}, 26'd0);
    check("reset_pulses", {init_start, swap_start, decode_start, core_reset}, 16'd0);
    check("reset_sel", addr_data_sel, 8'h00);
    check("reset_secret_key", secret_key, INIT_KEYS);
    reset = 1'b0;
  endtask

  task automatic start_search();
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    check("go_cycle1_init_start", init_start, 4'h0);
    check("go_cycle1_busy", busy, 1'b1);
    check("go_reload_keys", secret_key, INIT_KEYS);
    @(negedge clk);
    check("go_cycle2_init_start", init_start, 4'hF);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 1000 && done_seen == 0; k++) @(negedge clk);
    check("search_terminated", done_seen != 0, 1'b1);
  endtask

  task automatic post_checks(input res_t r, input int win, input logic [7:0] exp_sel);
    check("no_starts_after_verdict", post_starts, 0);
    check("decode_queue_drained", dec_exp_q.size(), 0);
    check("verdict_queue_drained", res_exp_q.size(), 0);
    check("core_resets_while_running", run_creset, r.kt);
    for (int c = 0; c < 4; c++)
      check($sformatf("core_reset_after_verdict_c%0d", c), post_creset[c],
            (r.p && c != win) ? 1 : 0);
    check("final_sel", addr_data_sel, exp_sel);
    check("sticky_verdict", {busy, pass, fail}, {1'b0, r.p, r.f});
    if (r.p) check("found_key_held", found_key, r.fk);
  endtask

  task automatic run_case(input int id, input int rounds, input res_t r,
                          input int win, input logic [7:0] exp_sel);
    test_id = id;
    do_reset();
    for (int i = 0; i < rounds; i++) push_round(i);
    res_exp_q.push_back(r);
    start_search();
    if (id == 5) begin
      repeat (6) @(negedge clk); go = 1'b1; @(negedge clk); go = 1'b0;
      repeat (15) @(negedge clk); go = 1'b1; @(negedge clk); go = 1'b0;
    end
    wait_done();
    repeat (10) @(negedge clk);
    post_checks(r, win, exp_sel);
  endtask

  initial begin
    reset = 1'b1; go = 1'b0;
    init_finish = '0; swap_finish = '0; decode_finish = '0; abort = '0;
    for (int c = 0; c < 4; c++) begin
      post_creset[c] = 0; last_swap[c] = 0;
    end
    for (int c = 0; c < 4; c++) begin
      automatic int cc = c;
      fork responder(cc); join_none
    end

    // 1: every key rejected -> fail after 16 keys
    run_case(1, 4, '{1'b0, 1'b1, 24'h0, 2'd0, 24'd16}, -1, 8'h00);
    // 2: core 2 cracks key 0x06
    run_case(2, 2, '{1'b1, 1'b0, 24'h06, 2'd2, 24'd4}, 2, 8'h30);
    // 3: cores 1 and 3 crack together -> lowest index wins
    run_case(3, 2, '{1'b1, 1'b0, 24'h05, 2'd1, 24'd4}, 1, 8'h0C);
    // 4: cracked and reject together on core 0 -> cracked, nothing counted
    run_case(4, 1, '{1'b1, 1'b0, 24'h00, 2'd0, 24'd0}, 0, 8'h03);
    // 5: out-of-phase strobes and go during the run are ignored
    run_case(5, 4, '{1'b0, 1'b1, 24'h0, 2'd0, 24'd16}, -1, 8'h00);

    // 6: asynchronous reset in the middle of a swap, then a clean restart
    test_id = 6;
    do_reset();
    push_round(0);
    start_search();
    for (int k = 0; k < 500 && !(keys_tested == 24'd4 && |swap_start); k++) @(negedge clk);
    check("t6_reached_second_swap", keys_tested == 24'd4 && |swap_start, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_async_busy_pass_fail", {busy, pass, fail}, 3'b000);
    check("t6_async_pulses", {init_start, swap_start, decode_start, core_reset}, 16'd0);
    check("t6_async_sel", addr_data_sel, 8'h00);
    check("t6_async_keys_tested", keys_tested, 24'd0);
    check("t6_async_secret_key", secret_key, INIT_KEYS);
    @(negedge clk); @(negedge clk);
    check("t6_no_decode_after_reset", dec_exp_q.size(), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push_round(i);
    res_exp_q.push_back('{1'b0, 1'b1, 24'h0, 2'd0, 24'd16});
    start_search();
    wait_done();
    repeat (10) @(negedge clk);
    post_checks('{1'b0, 1'b1, 24'h0, 2'd0, 24'd16}, -1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
